// File: rtl/line_buffer_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | line_buffer_sequencer_pkg : geometry defaults and FSM encodings    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package line_buffer_sequencer_pkg;

  localparam int PIX_IN_ROW_DFLT    = 640;
  localparam int ADC_WIDHT_DFLT     = 12;
  localparam int ROWS_IN_FRAME_DFLT = 480;
  localparam int ROW_W              = 10;
  localparam int CNT_W              = 10;

  typedef enum logic [1:0] {
    W_WAIT = 2'd0,
    W_FILL = 2'd1,
    W_DONE = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE     = 2'd0,
    R_WAIT_RDY = 2'd1,
    R_START    = 2'd2,
    R_READ     = 2'd3
  } rd_state_t;

  function automatic logic [ROW_W-1:0] row_inc_sat(input logic [ROW_W-1:0] row,
                                                   input logic [ROW_W-1:0] last);
    return (row >= last) ? row : row + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | line_buffer_sequencer_if : sensor/readout/buffer control bundle    |
// | Optional o_drop_cnt under LINE_SEQ_STATS_EN.          Rev 1.0      |
// +--------------------------------------------------------------------+
interface line_buffer_sequencer_if;
  import line_buffer_sequencer_pkg::*;

  logic             i_frame_start;
  logic             i_line_valid;
  logic             i_out_ready;
  logic             o_bufer_in_en;
  logic             o_bufer_change;
  logic             o_start_write;
  logic             o_bufer_out_en;
  logic [ROW_W-1:0] o_row_num;
  logic             o_overrun;
  logic             o_short_line;
`ifdef LINE_SEQ_STATS_EN
  logic [7:0]       o_drop_cnt;
`endif

  modport master (
    output i_frame_start, i_line_valid, i_out_ready,
    input  o_bufer_in_en, o_bufer_change, o_start_write, o_bufer_out_en,
           o_row_num, o_overrun, o_short_line
`ifdef LINE_SEQ_STATS_EN
           , o_drop_cnt
`endif
  );

  modport slave (
    input  i_frame_start, i_line_valid, i_out_ready,
    output o_bufer_in_en, o_bufer_change, o_start_write, o_bufer_out_en,
           o_row_num, o_overrun, o_short_line
`ifdef LINE_SEQ_STATS_EN
           , o_drop_cnt
`endif
  );

endinterface
`default_nettype wire

// File: rtl/line_buffer_sequencer_toggle_sync_2ff.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | toggle_sync_2ff : two-flop synchronizer for handshake toggles      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module toggle_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/line_buffer_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | line_buffer_sequencer : ping-pong line buffer write/read control   |
// | Optional drop counter under LINE_SEQ_STATS_EN.        Rev 1.0      |
// +--------------------------------------------------------------------+
module line_buffer_sequencer
  import line_buffer_sequencer_pkg::*;
#(
  parameter int PIX_IN_ROW    = PIX_IN_ROW_DFLT,
  parameter int ROWS_IN_FRAME = ROWS_IN_FRAME_DFLT
) (
  input  logic                    CLK1,
  input  logic                    CLK2,
  input  logic                    RESET,
  line_buffer_sequencer_if.slave  lb
);

  localparam logic [CNT_W-1:0] c_PIX_LAST = CNT_W'(PIX_IN_ROW - 1);
  localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(ROWS_IN_FRAME - 1);

  // ---------------- write side (CLK1) ----------------
  wr_state_t        r_wstate;
  wr_state_t        w_wnext;
  logic [CNT_W-1:0] r_wcnt;
  logic [ROW_W-1:0] r_row_cnt;
  logic [ROW_W-1:0] r_row_lat;
  logic             r_lv_d;
  logic             r_req;
  logic             r_bank;
  logic             r_in_en;
  logic             r_overrun;
  logic             r_short;
  logic             w_ack_sync;
  logic             w_lv_rise;
  logic             w_fill_last;
  logic             w_short;
  logic             w_accept;
  logic             w_drop;

  assign w_lv_rise   = lb.i_line_valid & ~r_lv_d;
  assign w_fill_last = (r_wcnt == c_PIX_LAST);

  always_ff @(posedge CLK1 or posedge RESET) begin
    if (RESET) r_wstate <= W_WAIT;
    else       r_wstate <= w_wnext;
  end

  always_comb begin
    w_wnext  = r_wstate;
    w_short  = 1'b0;
    w_accept = 1'b0;
    w_drop   = 1'b0;
    case (r_wstate)
      W_WAIT: if (w_lv_rise) w_wnext = W_FILL;
      W_FILL: begin
        if (w_fill_last) begin
          w_wnext = W_DONE;
        end else if (!lb.i_line_valid) begin
          w_wnext = W_WAIT;
          w_short = 1'b1;
        end
      end
      W_DONE: begin
        w_wnext = W_WAIT;
        // Read side idle only when its returned ack matches our request.
        if (r_req == w_ack_sync) w_accept = 1'b1;
        else                     w_drop   = 1'b1;
      end
      default: w_wnext = W_WAIT;
    endcase
  end

  always_ff @(posedge CLK1 or posedge RESET) begin
    if (RESET) begin
      r_lv_d    <= 1'b0;
      r_in_en   <= 1'b0;
      r_short   <= 1'b0;
      r_wcnt    <= '0;
      r_req     <= 1'b0;
      r_bank    <= 1'b0;
      r_row_lat <= '0;
      r_row_cnt <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_lv_d  <= lb.i_line_valid;
      r_in_en <= (w_wnext == W_FILL);
      r_short <= w_short;
      r_wcnt  <= (r_wstate == W_FILL) ? r_wcnt + 1'b1 : '0;
      if (w_accept) begin
        r_bank    <= ~r_bank;
        r_req     <= ~r_req;
        r_row_lat <= r_row_cnt;
      end
      if (lb.i_frame_start) begin
        r_row_cnt <= '0;
        r_overrun <= 1'b0;
      end else begin
        if (r_wstate == W_DONE) r_row_cnt <= row_inc_sat(r_row_cnt, c_ROW_LAST);
        if (w_drop)             r_overrun <= 1'b1;
      end
    end
  end

`ifdef LINE_SEQ_STATS_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge CLK1 or posedge RESET) begin
    if (RESET)                                        r_drop_cnt <= 8'd0;
    else if (lb.i_frame_start)                        r_drop_cnt <= 8'd0;
    else if ((w_drop | w_short) && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign lb.o_drop_cnt = r_drop_cnt;
`endif

  // ---------------- read side (CLK2) ----------------
  rd_state_t        r_rstate;
  rd_state_t        w_rnext;
  logic [CNT_W-1:0] r_rcnt;
  logic [ROW_W-1:0] r_row_num;
  logic             r_ack;
  logic             r_start_wr;
  logic             r_out_en;
  logic             w_req_sync;
  logic             w_read_last;

  assign w_read_last = (r_rcnt == c_PIX_LAST);

  always_ff @(posedge CLK2 or posedge RESET) begin
    if (RESET) r_rstate <= R_IDLE;
    else       r_rstate <= w_rnext;
  end

  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:     if (w_req_sync != r_ack) w_rnext = R_WAIT_RDY;
      R_WAIT_RDY: if (lb.i_out_ready)      w_rnext = R_START;
      R_START:                             w_rnext = R_READ;
      R_READ:     if (w_read_last)         w_rnext = R_IDLE;
      default:                             w_rnext = R_IDLE;
    endcase
  end

  // r_row_lat is stable here: the write side only updates it while we are idle.
  always_ff @(posedge CLK2 or posedge RESET) begin
    if (RESET) begin
      r_start_wr <= 1'b0;
      r_out_en   <= 1'b0;
      r_rcnt     <= '0;
      r_row_num  <= '0;
      r_ack      <= 1'b0;
    end else begin
      r_start_wr <= (w_rnext == R_START);
      r_out_en   <= (w_rnext == R_READ);
      r_rcnt     <= (r_rstate == R_READ) ? r_rcnt + 1'b1 : '0;
      if (r_rstate == R_WAIT_RDY && w_rnext == R_START) r_row_num <= r_row_lat;
      if (r_rstate == R_READ && w_read_last)            r_ack     <= ~r_ack;
    end
  end

  toggle_sync_2ff u_req_sync (
    .clk (CLK2),
    .rst (RESET),
    .i_d (r_req),
    .o_q (w_req_sync)
  );

  toggle_sync_2ff u_ack_sync (
    .clk (CLK1),
    .rst (RESET),
    .i_d (r_ack),
    .o_q (w_ack_sync)
  );

  assign lb.o_bufer_in_en  = r_in_en;
  assign lb.o_bufer_change = r_bank;
  assign lb.o_overrun      = r_overrun;
  assign lb.o_short_line   = r_short;
  assign lb.o_start_write  = r_start_wr;
  assign lb.o_bufer_out_en = r_out_en;
  assign lb.o_row_num      = r_row_num;

endmodule
`default_nettype wire

// File: tb/tb_line_buffer_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_line_buffer_sequencer : scoreboard bench for the sequencer      |
// | Honours LINE_SEQ_STATS_EN for the drop counter.       Rev 1.0      |
// +--------------------------------------------------------------------+
module tb_line_buffer_sequencer;
  import line_buffer_sequencer_pkg::*;

  localparam int PIX  = PIX_IN_ROW_DFLT;
  localparam int ROWS = ROWS_IN_FRAME_DFLT;

  logic CLK1  = 1'b0;
  logic CLK2  = 1'b0;
  logic RESET = 1'b1;

  line_buffer_sequencer_if lb_if();

  line_buffer_sequencer #(
    .PIX_IN_ROW    (PIX),
    .ROWS_IN_FRAME (ROWS)
  ) dut (
    .CLK1  (CLK1),
    .CLK2  (CLK2),
    .RESET (RESET),
    .lb    (lb_if)
  );

  always #6 CLK1 = ~CLK1;
  initial begin
    #1;
    forever #3 CLK2 = ~CLK2;
  end

  int n_checks = 0;
  int n_errors = 0;
  int exp_rows[$];
  int m_row = 0;
  int in_run = 0, last_in_len = 0, sl_cnt = 0;
  int oen_run = 0, rd_done = 0, sw_cnt = 0;
  logic prev_sw = 1'b0;

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({lb_if.o_bufer_in_en, lb_if.o_bufer_change, lb_if.o_start_write,
                 lb_if.o_bufer_out_en, lb_if.o_overrun, lb_if.o_short_line, lb_if.o_row_num});
  endfunction

  always @(negedge CLK1) begin
    if (lb_if.o_bufer_in_en) in_run++;
    else if (in_run > 0) begin
      last_in_len = in_run;
      in_run = 0;
    end
    if (lb_if.o_short_line) sl_cnt++;
  end

  always @(negedge CLK2) begin
    if (prev_sw && !RESET) check_val("sw_to_oen", int'(lb_if.o_bufer_out_en), 1);
    prev_sw = lb_if.o_start_write;
    if (lb_if.o_start_write) begin
      sw_cnt++;
      check_val("start_expected", int'(exp_rows.size() > 0), 1);
      if (exp_rows.size() > 0) check_val("row_num", int'(lb_if.o_row_num), exp_rows.pop_front());
    end
    if (lb_if.o_bufer_out_en) oen_run++;
    else if (oen_run > 0) begin
      if (!RESET) begin
        check_val("out_en_len", oen_run, PIX);
        rd_done++;
      end
      oen_run = 0;
    end
  end

  task automatic tick1(input int n);
    repeat (n) @(posedge CLK1);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    lb_if.i_frame_start = 1'b0;
    lb_if.i_line_valid  = 1'b0;
    lb_if.i_out_ready   = 1'b1;
    tick1(3);
    RESET = 1'b0;
    m_row = 0;
    exp_rows.delete();
    tick1(2);
  endtask

  task automatic frame_start();
    @(posedge CLK1); #1;
    lb_if.i_frame_start = 1'b1;
    m_row = 0;
    @(posedge CLK1); #1;
    lb_if.i_frame_start = 1'b0;
  endtask

  task automatic drive_row(input int len, input int gap);
    @(posedge CLK1); #1;
    lb_if.i_line_valid = 1'b1;
    repeat (len) @(posedge CLK1);
    #1;
    lb_if.i_line_valid = 1'b0;
    repeat (gap) @(posedge CLK1);
    #1;
  endtask

  // Full row; the scenario decides whether the read side should be free.
  task automatic drive_full(input bit accept);
    if (accept) exp_rows.push_back(m_row);
    drive_row(PIX, 4);
    if (m_row < ROWS - 1) m_row++;
  endtask

  task automatic wait_reads(input int target);
    int b = 0;
    while (rd_done < target && b < 20000) begin
      @(negedge CLK2);
      b++;
    end
    check_val("reads_done", rd_done, target);
  endtask

  initial begin
    #400_000_0;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sw0, sl0, rd0, b;
    lb_if.i_frame_start = 1'b0;
    lb_if.i_line_valid  = 1'b0;
    lb_if.i_out_ready   = 1'b1;
    tick1(3);
    check_val("reset_outs", outs(), 0);
    RESET = 1'b0;
    tick1(2);
    check_val("post_reset_outs", outs(), 0);

    // Single row
    frame_start();
    sw0 = sw_cnt; rd0 = rd_done;
    drive_full(1'b1);
    wait_reads(rd0 + 1);
    check_val("t1_in_len", last_in_len, PIX);
    check_val("t1_bank", int'(lb_if.o_bufer_change), 1);
    check_val("t1_starts", sw_cnt - sw0, 1);
    check_val("t1_overrun", int'(lb_if.o_overrun), 0);

    // Two rows back to back
    do_reset();
    frame_start();
    rd0 = rd_done;
    drive_full(1'b1);
    drive_full(1'b1);
    wait_reads(rd0 + 2);
    check_val("t2_bank", int'(lb_if.o_bufer_change), 0);
    check_val("t2_overrun", int'(lb_if.o_overrun), 0);
    check_val("t2_queue", exp_rows.size(), 0);

    // Readout stalled across two rows
    do_reset();
    frame_start();
    lb_if.i_out_ready = 1'b0;
    sw0 = sw_cnt; rd0 = rd_done;
    drive_full(1'b1);
    drive_full(1'b0);
    tick1(5);
    check_val("t3_overrun", int'(lb_if.o_overrun), 1);
    check_val("t3_bank", int'(lb_if.o_bufer_change), 1);
    check_val("t3_no_start", sw_cnt - sw0, 0);
`ifdef LINE_SEQ_STATS_EN
    check_val("t3_drop_cnt", int'(lb_if.o_drop_cnt), 1);
`endif
    lb_if.i_out_ready = 1'b1;
    wait_reads(rd0 + 1);

    // Short line
    do_reset();
    frame_start();
    sl0 = sl_cnt; sw0 = sw_cnt;
    drive_row(300, 10);
    check_val("t4_short_pulses", sl_cnt - sl0, 1);
    check_val("t4_in_len", last_in_len, 300);
    check_val("t4_bank", int'(lb_if.o_bufer_change), 0);
    repeat (200) @(negedge CLK2);
    check_val("t4_no_start", sw_cnt - sw0, 0);
`ifdef LINE_SEQ_STATS_EN
    check_val("t4_drop_cnt", int'(lb_if.o_drop_cnt), 1);
`endif
    rd0 = rd_done;
    drive_full(1'b1);
    wait_reads(rd0 + 1);
    check_val("t4_bank_after", int'(lb_if.o_bufer_change), 1);

    // Reset in the middle of a readout
    do_reset();
    frame_start();
    drive_full(1'b1);
    b = 0;
    while (oen_run < 200 && b < 20000) begin
      @(negedge CLK2);
      b++;
    end
    check_val("t5_reached_200", int'(oen_run >= 200), 1);
    #1;
    RESET = 1'b1;
    #1;
    check_val("t5_reset_outs", outs(), 0);
    tick1(3);
    RESET = 1'b0;
    m_row = 0;
    exp_rows.delete();
    tick1(2);
    rd0 = rd_done;
    drive_full(1'b1);
    wait_reads(rd0 + 1);

    // Frame start clears overrun and row counter
    do_reset();
    frame_start();
    lb_if.i_out_ready = 1'b0;
    rd0 = rd_done;
    drive_full(1'b1);
    for (int i = 0; i < 4; i++) drive_full(1'b0);
    check_val("t6_overrun_set", int'(lb_if.o_overrun), 1);
`ifdef LINE_SEQ_STATS_EN
    check_val("t6_drop_cnt", int'(lb_if.o_drop_cnt), 4);
`endif
    frame_start();
    tick1(1);
    check_val("t6_overrun_clr", int'(lb_if.o_overrun), 0);
`ifdef LINE_SEQ_STATS_EN
    check_val("t6_drop_clr", int'(lb_if.o_drop_cnt), 0);
`endif
    lb_if.i_out_ready = 1'b1;
    wait_reads(rd0 + 1);
    drive_full(1'b1);
    wait_reads(rd0 + 2);
    check_val("t6_overrun_end", int'(lb_if.o_overrun), 0);

    check_val("queue_empty_final", exp_rows.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
